// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump controller:
// state encoding and the default widths of the MIPS register file.
package regfile_dump_ctrl_pkg;

    localparam int LEN_DEF     = 32;
    localparam int NB_REG_DEF  = 32;
    localparam int NB_ADDR_DEF = 5;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HALT_WAIT = 3'd1;
    localparam logic [2:0] ST_ADDR      = 3'd2;
    localparam logic [2:0] ST_READ      = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_HALT_WAIT = ST_HALT_WAIT,
        S_ADDR      = ST_ADDR,
        S_READ      = ST_READ,
        S_SEND      = ST_SEND,
        S_DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug dump controller: halts the pipeline, borrows register-file read
// port 1, and streams every register out over a valid/ready link.
// Outside a dump the read address and write enable pass straight through.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int LEN     = LEN_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dump_start,
    input  logic               i_pipe_halted,
    output logic               o_halt_req,
    input  logic [NB_ADDR-1:0] i_pipe_read_register_1,
    output logic [NB_ADDR-1:0] o_read_register_1,
    input  logic               i_pipe_RegWrite,
    output logic               o_RegWrite,
    input  logic [LEN-1:0]     i_read_data_1,
    output logic [LEN-1:0]     o_dump_data,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    // Termination compares against the last index, so a full 2**NB_ADDR
    // register file never needs the counter to wrap.
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(NB_REG - 1);

    state_t             state;
    logic [NB_ADDR-1:0] counter;
    logic               port_owned;

    // Dump sequencer: state, register index and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            counter      <= '0;
            o_halt_req   <= 1'b0;
            o_dump_data  <= '0;
            o_dump_addr  <= '0;
            o_dump_valid <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_dump_start) begin
                        state      <= S_HALT_WAIT;
                        counter    <= '0;
                        o_err      <= 1'b0;
                        o_halt_req <= 1'b1;
                    end
                end
                S_HALT_WAIT: begin
                    if (i_pipe_halted) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // Register file samples the address at this edge.
                    if (!i_pipe_halted) begin
                        o_err <= 1'b1;
                    end
                    state <= S_READ;
                end
                S_READ: begin
                    if (!i_pipe_halted) begin
                        o_err <= 1'b1;
                    end
                    o_dump_data  <= i_read_data_1;
                    o_dump_addr  <= counter;
                    o_dump_valid <= 1'b1;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    if (!i_pipe_halted) begin
                        o_err <= 1'b1;
                    end
                    if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        if (counter == LAST_IDX) begin
                            state      <= S_DONE;
                            o_done     <= 1'b1;
                            o_halt_req <= 1'b0;
                        end else begin
                            counter <= counter + 1'b1;
                            state   <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read port 1 belongs to the controller only while it is walking registers.
    always_comb begin
        port_owned = (state == S_ADDR) || (state == S_READ) || (state == S_SEND);
    end

    // Combinational port mux, write gate and busy flag; the register file
    // writes on negedge, so the gate must follow the state without delay.
    always_comb begin
        o_read_register_1 = port_owned ? counter : i_pipe_read_register_1;
        o_RegWrite        = (state == S_IDLE) ? i_pipe_RegWrite : 1'b0;
        o_busy            = (state != S_IDLE);
    end

endmodule
